// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a registered
// write stage and a busy scoreboard for outstanding multi-cycle writes.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  input  logic               claim_valid,
  input  logic [AW-1:0]      claim_addr,
  output logic               claim_err,
  input  logic [AW-1:0]      chk_addr1,
  input  logic [AW-1:0]      chk_addr2,
  output logic               chk_busy1,
  output logic               chk_busy2,
  output logic [2**AW-1:0]   busy
);

  localparam int NR = 2**AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            accept;

  // Requests at or above ptr win; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = ~((NREQ'(1) << ptr_q) - NREQ'(1));
    masked  = req_valid & hi_mask;
    cand    = (|masked) ? masked : req_valid;
    gnt     = stall ? '0 : (cand & (~cand + NREQ'(1)));
  end

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign accept    = |gnt;
  assign req_ready = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
    end
    we_d    = accept && (sel_addr != '0);
    waddr_d = accept ? sel_addr : waddr_q;
    wdata_d = accept ? sel_data : wdata_q;
    busy_d  = busy_q;
    if (we_d) begin
      busy_d[sel_addr] = 1'b0;
    end
    // A same-cycle claim is the younger op, so its set overrides the clear.
    if (claim_valid && (claim_addr != '0)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    err_d = claim_valid && (claim_addr != '0) && busy_q[claim_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign claim_err = err_q;
  assign busy      = busy_q;
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic
// against a behavioural model of arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               claim_valid;
  logic [AW-1:0]      claim_addr;
  logic               claim_err;
  logic [AW-1:0]      chk_addr1;
  logic [AW-1:0]      chk_addr2;
  logic               chk_busy1;
  logic               chk_busy2;
  logic [2**AW-1:0]   busy;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_err   (claim_err),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // model state
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_err;
  int          last_g;

  // requester holding registers
  logic        pend_v [NREQ];
  logic [4:0]  pend_a [NREQ];
  logic [31:0] pend_d [NREQ];

  int          rr_exp  [4];
  logic [4:0]  rr_addr [4];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_d[i] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend_v[i];
      req_addr[i*AW +: AW]  = pend_a[i];
      req_data[i*DW +: DW]  = pend_d[i];
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    int          g;
    logic [NREQ-1:0] exp_rdy;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] nb;
    #1;
    g = -1;
    if (!stall) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    chk("chk_busy1", 64'(chk_busy1), 64'(m_busy[chk_addr1]));
    chk("chk_busy2", 64'(chk_busy2), 64'(m_busy[chk_addr2]));
    @(posedge clk);
    nb    = m_busy;
    m_err = claim_valid && (claim_addr != 0) && m_busy[claim_addr];
    m_we  = 1'b0;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      d = req_data[g*DW +: DW];
      m_we    = (a != 0);
      m_waddr = a;
      m_wdata = d;
      m_ptr   = (g + 1) % NREQ;
      if (a != 0) nb[a] = 1'b0;
    end
    if (claim_valid && claim_addr != 0) nb[claim_addr] = 1'b1;
    m_busy = nb;
    last_g = g;
    @(negedge clk);
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("claim_err", 64'(claim_err), 64'(m_err));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last_g = -1;
    rr_exp  = '{0, 1, 2, 0};
    rr_addr = '{5'd5, 5'd6, 5'd7, 5'd5};
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_d[i] = '0;
    end

    // reset held with random inputs
    rst         = 1'b0;
    stall       = 1'($urandom);
    req_valid   = NREQ'($urandom);
    req_addr    = NREQ*AW'($urandom);
    req_data    = {$urandom, $urandom, $urandom};
    claim_valid = 1'b1;
    claim_addr  = 5'd9;
    chk_addr1   = 5'd9;
    chk_addr2   = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(claim_err), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    model_reset();
    stall       = 1'b0;
    claim_valid = 1'b0;
    drive();
    rst = 1'b1;

    // round robin from ptr=0
    set_req(0, 5'd5, 32'hAAAA_0001);
    set_req(1, 5'd6, 32'hBBBB_0002);
    set_req(2, 5'd7, 32'hCCCC_0003);
    for (int r = 0; r < 4; r++) begin
      drive();
      step();
      chk("rr_gnt", 64'(last_g), 64'(rr_exp[r]));
      chk("rr_waddr", 64'(rf_waddr), 64'(rr_addr[r]));
    end
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;

    // write to r0
    set_req(1, 5'd0, 32'hFFFF_FFFF);
    drive();
    step();
    chk("zero_hs", 64'(last_g), 64'd1);
    chk("zero_we", 64'(rf_we), 64'd0);
    pend_v[1] = 1'b0;

    // claim r9, wait, then write it back
    claim_valid = 1'b1;
    claim_addr  = 5'd9;
    drive();
    step();
    claim_valid = 1'b0;
    chk_addr1   = 5'd9;
    repeat (3) step();
    chk("sb_busy", 64'(chk_busy1), 64'd1);
    set_req(2, 5'd9, 32'h1234_5678);
    drive();
    step();
    chk("sb_clr", 64'(busy[9]), 64'd0);
    chk("sb_we", 64'(rf_we), 64'd1);
    chk("sb_waddr", 64'(rf_waddr), 64'd9);
    pend_v[2] = 1'b0;

    // claim and write to r9 in the same cycle
    claim_valid = 1'b1;
    drive();
    step();
    set_req(0, 5'd9, 32'h0BAD_F00D);
    drive();
    step();
    chk("col_busy", 64'(busy[9]), 64'd1);
    pend_v[0] = 1'b0;
    drive();
    step();
    chk("col_err", 64'(claim_err), 64'd1);
    claim_valid = 1'b0;
    step();
    chk("col_err_off", 64'(claim_err), 64'd0);

    // stall does not block the in-flight write
    set_req(0, 5'd1, 32'h1111_1111);
    set_req(1, 5'd2, 32'h2222_2222);
    set_req(2, 5'd3, 32'h3333_3333);
    drive();
    step();
    stall = 1'b1;
    #1;
    chk("stall_rdy", 64'(req_ready), 64'd0);
    chk("stall_we", 64'(rf_we), 64'd1);
    step();
    stall = 1'b0;

    // reset right after an accept drops the write
    claim_valid = 1'b1;
    claim_addr  = 5'd12;
    step();
    claim_valid = 1'b0;
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    model_reset();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && ($urandom % 3 == 0))
          set_req(i, 5'($urandom % 8), $urandom);
      end
      stall       = ($urandom % 5 == 0);
      claim_valid = ($urandom % 4 == 0);
      claim_addr  = 5'($urandom % 8);
      chk_addr1   = 5'($urandom % 8);
      chk_addr2   = 5'($urandom % 8);
      drive();
      step();
      if (last_g >= 0) pend_v[last_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we/waddr/wdata) among NREQ writeback requesters: ALU writeback, load unit, and multi-cycle mult/div.
- Round-robin arbiter with valid/ready handshakes and a registered write stage.
- Carries a 32-entry busy scoreboard so decode can detect RAW hazards on registers with outstanding multi-cycle writes.
- Sits between the execute/memory units and the register file.

Parameters:
- NREQ, 3, number of write requesters (2..4).
- DW, 32, data width.
- AW, 5, register address width; the scoreboard has 2**AW entries.

Ports:
- clk  in  1  clock, rising edge; the register file captures on the following falling edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  high: no grants this cycle.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant; combinational.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW].
- rf_we  out  1  register-file write enable; registered.
- rf_waddr  out  AW  register-file write address; registered.
- rf_wdata  out  DW  register-file write data; registered.
- claim_valid  in  1  a multi-cycle op has issued with destination claim_addr.
- claim_addr  in  AW  destination register to mark busy.
- claim_err  out  1  registered one-cycle pulse: claim to an already-busy register.
- chk_addr1  in  AW  decode source address 1.
- chk_addr2  in  AW  decode source address 2.
- chk_busy1  out  1  combinational: busy[chk_addr1].
- chk_busy2  out  1  combinational: busy[chk_addr2].
- busy  out  2**AW  scoreboard vector.

Behaviour:
- Reset (rst=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, ptr=0, claim_err=0. An accepted write still in the output stage is dropped. Reset asserted mid-operation loses all pending busy bits.
- Arbitration:
  - ptr (0..NREQ-1) is the highest-priority index.
  - Grant the first i with req_valid[i], scanning ptr, ptr+1, … mod NREQ.
  - At most one req_ready bit is high. req_ready is 0 for all requesters when stall=1.
  - Handshake completes when req_valid[i] && req_ready[i].
  - Requesters hold valid/addr/data stable until accepted. req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Pointer update: after a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds. A continuously valid requester is granted within NREQ cycles.
- Write stage, one cycle latency from accept:
  - On accept at edge k, the registered outputs at k+1 are rf_we=1, rf_waddr=req_addr[i], rf_wdata=req_data[i].
  - With no accept, rf_we=0 and rf_waddr/rf_wdata hold.
  - An accepted write to address 0 completes the handshake but produces rf_we=0 (r0 stays hardwired to zero).
- Scoreboard:
  - busy[0] is constant 0.
  - claim_valid with claim_addr≠0 sets busy[claim_addr] at the next edge.
  - An accepted write to a≠0 clears busy[a] at the next edge. An unclaimed write to a non-busy register is legal and has no scoreboard effect.
  - Claim and accepted write to the same address in the same cycle: set wins, busy stays 1 (the claim is the younger op).
  - Claim to an already-busy address: busy stays 1 and claim_err pulses 1 for one cycle. There is no reference counting.
  - chk_busy reflects the registered busy bits. It does not bypass same-cycle claims or clears.
- Stall: blocks new grants only. A write already in the output stage still issues.

Test Plan:
- Reset: hold rst=0 with random inputs → rf_we=0, busy=0, claim_err=0. Release; ptr=0 confirmed by the first grant going to req0 when all are valid.
- Round robin: all three valid continuously, addrs 5/6/7, data A/B/C → grant order 0,1,2,0. rf_waddr sequence 5,6,7,5, each one cycle after its accept.
- Zero register: req1 valid with addr 0, data FFFFFFFF → req_ready[1]=1 and the handshake completes. Next cycle rf_we=0; busy unchanged.
- Scoreboard: claim r9, then 3 idle cycles → chk_busy1=1 with chk_addr1=9. req2 writes r9 → busy[9]=0 the following cycle and rf_we=1, rf_waddr=9.
- Collision: r9 busy; same cycle claim r9 and accept a write to r9 → busy[9] stays 1. A second claim to r9 → claim_err=1 for exactly one cycle.
- Stall/reset: stall=1 with all valid → req_ready=0, and the in-flight write still reaches rf_we=1. Assert rst the cycle after an accept → rf_we forced to 0 immediately, write dropped.
